// File: rtl/cam_pkg.sv
// -----------------------------------------------------------------------------
// cam_pkg
// Shared types and constants for the DVP camera emulator.
//   cam_state_t  : frame FSM states, stepped one line period at a time
//   PAT_*        : pattern_sel encodings (3 is reserved and renders as bars)
//   BAR_RGB      : RGB565 colour-bar values, left to right
// -----------------------------------------------------------------------------
package cam_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBP,
    ST_ACTIVE,
    ST_VFP
  } cam_state_t;

  localparam logic [1:0] PAT_BARS    = 2'd0;
  localparam logic [1:0] PAT_COUNTER = 2'd1;
  localparam logic [1:0] PAT_SOLID   = 2'd2;

  // White, yellow, cyan, green, magenta, red, blue, black
  localparam logic [15:0] BAR_RGB [8] = '{
    16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
    16'hF81F, 16'hF800, 16'h001F, 16'h0000
  };

endpackage

// File: rtl/cam_pattern_gen.sv
// -----------------------------------------------------------------------------
// cam_pattern_gen
// Combinational test-pattern byte generator; the top registers its output.
//   i_x     : pixel column within the active line
//   i_y     : active line index
//   i_bsel  : 0 = high byte of the RGB565 pixel, 1 = low byte
//   i_bar   : colour-bar index, maintained by the top as a sub-counter
//   i_mode  : latched pattern select
//   i_solid : latched RGB565 value for solid mode
//   o_byte  : byte to put on the DVP bus
// -----------------------------------------------------------------------------
module cam_pattern_gen
  import cam_pkg::*;
#(
  parameter int X_W = 10,
  parameter int Y_W = 10
) (
  input  logic [X_W-1:0] i_x,
  input  logic [Y_W-1:0] i_y,
  input  logic           i_bsel,
  input  logic [2:0]     i_bar,
  input  logic [1:0]     i_mode,
  input  logic [15:0]    i_solid,
  output logic [7:0]     o_byte
);

  logic [15:0] w_bar_pix;
  logic [7:0]  w_bar_byte;
  logic [7:0]  w_count;

  always_comb begin
    w_bar_pix  = BAR_RGB[i_bar];
    w_bar_byte = i_bsel ? w_bar_pix[7:0] : w_bar_pix[15:8];
    // {x, bsel} is the byte index within the line; the 8-bit sum wraps mod 256
    w_count    = 8'({i_x, i_bsel}) + 8'(i_y);
    case (i_mode)
      PAT_SOLID:   o_byte = i_bsel ? i_solid[7:0] : i_solid[15:8];
      PAT_COUNTER: o_byte = w_count;
      PAT_BARS:    o_byte = w_bar_byte;
      default:     o_byte = w_bar_byte;  // reserved encoding renders as bars
    endcase
  end

endmodule

// File: rtl/cam_dvp_emu.sv
// -----------------------------------------------------------------------------
// cam_dvp_emu
// DVP image-sensor emulator: streams RGB565 test frames (high byte first)
// as pclk / vsync / href / 8-bit data, all derived from sys_clk_i.
//   sys_clk_i     : system clock (pclk_o = sys_clk_i / 2)
//   sys_rst_i     : asynchronous active-low reset
//   enable_i      : frames stream while high; sampled only at frame boundaries
//   pattern_sel_i : 0 bars, 1 counter, 2 solid, 3 bars; latched per frame
//   solid_rgb_i   : RGB565 value for solid mode; latched per frame
//   pclk_o        : pixel clock
//   vsync_o       : frame sync, high during the VSYNC lines
//   href_o        : line valid, high for 2*H_ACTIVE pclk of each active line
//   cam_data_o    : pixel byte, zero while href_o is low
//   frame_done_o  : one sys_clk pulse on the last pclk fall of each frame
//   frame_cnt_o   : completed-frame counter, wraps
// -----------------------------------------------------------------------------
module cam_dvp_emu
  import cam_pkg::*;
#(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int H_BLANK     = 144,
  parameter int VSYNC_LINES = 3,
  parameter int V_BP_LINES  = 17,
  parameter int V_FP_LINES  = 10
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_i,
  input  logic        enable_i,
  input  logic [1:0]  pattern_sel_i,
  input  logic [15:0] solid_rgb_i,
  output logic        pclk_o,
  output logic        vsync_o,
  output logic        href_o,
  output logic [7:0]  cam_data_o,
  output logic        frame_done_o,
  output logic [15:0] frame_cnt_o
);

  localparam int LINE_P = 2 * H_ACTIVE + H_BLANK;
  localparam int H_W    = $clog2(LINE_P);
  localparam int V_W    = $clog2(VSYNC_LINES + V_BP_LINES + V_ACTIVE + V_FP_LINES + 1);
  localparam int X_W    = $clog2(H_ACTIVE);
  localparam int BAR_P  = H_ACTIVE / 4;          // pclk periods per colour bar
  localparam int B_W    = $clog2(BAR_P + 1);

  localparam logic [H_W-1:0] H_LAST    = H_W'(LINE_P - 1);
  localparam logic [H_W-1:0] H_HREF    = H_W'(2 * H_ACTIVE);
  localparam logic [B_W-1:0] BAR_LAST  = B_W'(BAR_P - 1);
  localparam logic [V_W-1:0] VS_LAST   = V_W'(VSYNC_LINES - 1);
  localparam logic [V_W-1:0] VBP_LAST  = V_W'(V_BP_LINES - 1);
  localparam logic [V_W-1:0] ACT_LAST  = V_W'(V_ACTIVE - 1);
  localparam logic [V_W-1:0] VFP_LAST  = V_W'(V_FP_LINES - 1);

  // Position registers describe what the output registers currently show.
  logic             r_ph;
  cam_state_t       r_state;
  logic [H_W-1:0]   r_hcnt;
  logic [V_W-1:0]   r_vcnt;
  logic [2:0]       r_bar;
  logic [B_W-1:0]   r_bar_cnt;
  logic [1:0]       r_mode;
  logic [15:0]      r_solid;
  logic             r_vsync;
  logic             r_href;
  logic [7:0]       r_data;
  logic             r_done;
  logic [15:0]      r_fcnt;

  logic             w_fall;
  logic             w_line_end;
  logic             w_last_line;
  cam_state_t       w_state_n;
  logic [H_W-1:0]   w_hcnt_n;
  logic [V_W-1:0]   w_vcnt_n;
  logic [2:0]       w_bar_n;
  logic [B_W-1:0]   w_bar_cnt_n;
  logic             w_latch;
  logic             w_done;
  logic             w_href_n;
  logic [7:0]       w_pat_byte;

  // A fall tick is the edge on which ph goes 1 -> 0.
  assign w_fall     = r_ph;
  assign w_line_end = (r_hcnt == H_LAST);

  always_comb begin
    case (r_state)
      ST_VSYNC:  w_last_line = (r_vcnt == VS_LAST);
      ST_VBP:    w_last_line = (r_vcnt == VBP_LAST);
      ST_ACTIVE: w_last_line = (r_vcnt == ACT_LAST);
      ST_VFP:    w_last_line = (r_vcnt == VFP_LAST);
      default:   w_last_line = 1'b0;
    endcase
  end

  // Next position: one pclk period per fall tick, one state per group of lines.
  always_comb begin
    w_state_n = r_state;
    w_hcnt_n  = r_hcnt;
    w_vcnt_n  = r_vcnt;
    w_latch   = 1'b0;
    w_done    = 1'b0;
    if (w_fall) begin
      if (r_state == ST_IDLE) begin
        if (enable_i) begin
          w_state_n = ST_VSYNC;
          w_hcnt_n  = '0;
          w_vcnt_n  = '0;
          w_latch   = 1'b1;
        end
      end else if (w_line_end) begin
        w_hcnt_n = '0;
        if (w_last_line) begin
          w_vcnt_n = '0;
          case (r_state)
            ST_VSYNC:  w_state_n = ST_VBP;
            ST_VBP:    w_state_n = ST_ACTIVE;
            ST_ACTIVE: w_state_n = ST_VFP;
            ST_VFP: begin
              // Frame boundary: the only point enable_i matters mid-stream.
              w_done = 1'b1;
              if (enable_i) begin
                w_state_n = ST_VSYNC;
                w_latch   = 1'b1;
              end else begin
                w_state_n = ST_IDLE;
              end
            end
            default:   w_state_n = ST_IDLE;
          endcase
        end else begin
          w_vcnt_n = r_vcnt + V_W'(1);
        end
      end else begin
        w_hcnt_n = r_hcnt + H_W'(1);
      end
    end
  end

  // Colour-bar index tracked with a sub-counter instead of dividing x.
  always_comb begin
    w_bar_n     = r_bar;
    w_bar_cnt_n = r_bar_cnt;
    if (w_fall) begin
      if (w_hcnt_n == '0) begin
        w_bar_n     = '0;
        w_bar_cnt_n = '0;
      end else if (r_bar_cnt == BAR_LAST) begin
        w_bar_n     = r_bar + 3'd1;
        w_bar_cnt_n = '0;
      end else begin
        w_bar_cnt_n = r_bar_cnt + B_W'(1);
      end
    end
  end

  assign w_href_n = (w_state_n == ST_ACTIVE) && (w_hcnt_n < H_HREF);

  cam_pattern_gen #(
    .X_W (X_W),
    .Y_W (V_W)
  ) u_pattern (
    .i_x     (w_hcnt_n[X_W:1]),
    .i_y     (w_vcnt_n),
    .i_bsel  (w_hcnt_n[0]),
    .i_bar   (w_bar_n),
    .i_mode  (r_mode),
    .i_solid (r_solid),
    .o_byte  (w_pat_byte)
  );

  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      r_ph      <= 1'b0;
      r_state   <= ST_IDLE;
      r_hcnt    <= '0;
      r_vcnt    <= '0;
      r_bar     <= '0;
      r_bar_cnt <= '0;
      r_mode    <= PAT_BARS;
      r_solid   <= '0;
      r_vsync   <= 1'b0;
      r_href    <= 1'b0;
      r_data    <= '0;
      r_done    <= 1'b0;
      r_fcnt    <= '0;
    end else begin
      r_ph      <= ~r_ph;
      r_state   <= w_state_n;
      r_hcnt    <= w_hcnt_n;
      r_vcnt    <= w_vcnt_n;
      r_bar     <= w_bar_n;
      r_bar_cnt <= w_bar_cnt_n;
      r_done    <= w_done;
      if (w_done) begin
        r_fcnt <= r_fcnt + 16'd1;
      end
      if (w_latch) begin
        r_mode  <= pattern_sel_i;
        r_solid <= solid_rgb_i;
      end
      // Bus outputs move only on fall ticks so they are stable at pclk rise.
      if (w_fall) begin
        r_vsync <= (w_state_n == ST_VSYNC);
        r_href  <= w_href_n;
        r_data  <= w_href_n ? w_pat_byte : 8'h00;
      end
    end
  end

  assign pclk_o       = r_ph;
  assign vsync_o      = r_vsync;
  assign href_o       = r_href;
  assign cam_data_o   = r_data;
  assign frame_done_o = r_done;
  assign frame_cnt_o  = r_fcnt;

endmodule

// File: tb/tb_cam_dvp_emu.sv
module tb_cam_dvp_emu;

  localparam int HA     = 8;
  localparam int VA     = 2;
  localparam int HB     = 3;
  localparam int VS     = 1;
  localparam int VBP    = 1;
  localparam int VFP    = 1;
  localparam int LINE_P = 2 * HA + HB;                 // 19 pclk
  localparam int FRAME_P = LINE_P * (VS + VBP + VA + VFP);  // 95 pclk

  localparam logic [15:0] BARS [8] = '{
    16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
    16'hF81F, 16'hF800, 16'h001F, 16'h0000
  };
  localparam logic [7:0] BAR_BYTES [16] = '{
    8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
    8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00
  };

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [1:0]  sel = 2'd0;
  logic [15:0] solid = 16'h0000;
  logic        pclk_o, vsync_o, href_o, frame_done_o;
  logic [7:0]  cam_data_o;
  logic [15:0] frame_cnt_o;

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cam_dvp_emu #(
    .H_ACTIVE    (HA),
    .V_ACTIVE    (VA),
    .H_BLANK     (HB),
    .VSYNC_LINES (VS),
    .V_BP_LINES  (VBP),
    .V_FP_LINES  (VFP)
  ) dut (
    .sys_clk_i     (clk),
    .sys_rst_i     (rst_n),
    .enable_i      (en),
    .pattern_sel_i (sel),
    .solid_rgb_i   (solid),
    .pclk_o        (pclk_o),
    .vsync_o       (vsync_o),
    .href_o        (href_o),
    .cam_data_o    (cam_data_o),
    .frame_done_o  (frame_done_o),
    .frame_cnt_o   (frame_cnt_o)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string nm);
    n_checks++;
    n_err++;
    $display("FAIL %s: timed out waiting for frame_done", nm);
  endtask

  // ---- Frame-level model: position k counts pclk periods from frame start ----
  int          m_k = 0;
  bit          m_in = 1'b0;
  bit          m_ph = 1'b0;
  bit          m_done = 1'b0;
  logic [15:0] m_fcnt = 16'h0;
  logic [1:0]  m_mode = 2'd0;
  logic [15:0] m_solid = 16'h0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_k <= 0; m_in <= 1'b0; m_ph <= 1'b0; m_done <= 1'b0;
      m_fcnt <= 16'h0; m_mode <= 2'd0; m_solid <= 16'h0;
    end else begin
      m_ph   <= !m_ph;
      m_done <= 1'b0;
      if (m_ph) begin
        if (!m_in) begin
          if (en) begin
            m_in <= 1'b1; m_k <= 0; m_mode <= sel; m_solid <= solid;
          end
        end else if (m_k == FRAME_P - 1) begin
          m_done <= 1'b1;
          m_fcnt <= m_fcnt + 16'd1;
          if (en) begin
            m_k <= 0; m_mode <= sel; m_solid <= solid;
          end else begin
            m_in <= 1'b0;
          end
        end else begin
          m_k <= m_k + 1;
        end
      end
    end
  end

  function automatic bit exp_active(input int k);
    int line, col;
    line = k / LINE_P;
    col  = k % LINE_P;
    return (line >= VS + VBP) && (line < VS + VBP + VA) && (col < 2 * HA);
  endfunction

  function automatic logic [7:0] exp_byte(input int k, input logic [1:0] mode, input logic [15:0] sv);
    int line, col, y, x;
    logic [15:0] pix;
    if (!exp_active(k)) return 8'h00;
    line = k / LINE_P;
    col  = k % LINE_P;
    y    = line - (VS + VBP);
    x    = col / 2;
    case (mode)
      2'd1:    return 8'((col + y) % 256);
      2'd2:    pix = sv;
      default: pix = BARS[x / (HA / 8)];
    endcase
    return (col % 2 == 1) ? pix[7:0] : pix[15:8];
  endfunction

  // ---- Continuous comparison against the model ----
  always @(negedge clk) begin
    logic       ev, eh;
    logic [7:0] eb;
    ev = m_in && (m_k < LINE_P * VS);
    eh = m_in && exp_active(m_k);
    eb = m_in ? exp_byte(m_k, m_mode, m_solid) : 8'h00;
    chk("model_pclk",  32'(pclk_o),       32'(m_ph));
    chk("model_vsync", 32'(vsync_o),      32'(ev));
    chk("model_href",  32'(href_o),       32'(eh));
    chk("model_data",  32'(cam_data_o),   32'(eb));
    chk("model_done",  32'(frame_done_o), 32'(m_done));
    chk("model_fcnt",  32'(frame_cnt_o),  32'(m_fcnt));
  end

  task automatic wait_done(input string nm, output int t);
    bit ok;
    ok = 1'b0;
    t  = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (frame_done_o) begin
        ok = 1'b1;
        t  = cyc;
        break;
      end
    end
    if (!ok) timeout(nm);
  endtask

  initial begin
    int         t0, t1, t2, vs_n, hr_n, nb, bad;
    bit         ok, seen_vs;
    logic       prev_href;
    logic [7:0] bytes [32];

    for (int i = 0; i < 32; i++) bytes[i] = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_pclk",  32'(pclk_o),       32'h0);
    chk("rst_vsync", 32'(vsync_o),      32'h0);
    chk("rst_href",  32'(href_o),       32'h0);
    chk("rst_data",  32'(cam_data_o),   32'h0);
    chk("rst_done",  32'(frame_done_o), 32'h0);
    chk("rst_fcnt",  32'(frame_cnt_o),  32'h0);

    // Frame 1: bars, enable raised together with reset release
    rst_n = 1'b1; en = 1'b1; sel = 2'd0;
    @(negedge clk); chk("vs_latency_rise", 32'(vsync_o), 32'h0);
    @(negedge clk); chk("vs_latency_fall", 32'(vsync_o), 32'h1);
    vs_n = 0; hr_n = 0; nb = 0; ok = 1'b0; t0 = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (pclk_o && vsync_o) vs_n++;
      if (pclk_o && href_o) begin
        if (nb < 32) bytes[nb] = cam_data_o;
        nb++; hr_n++;
      end
      if (frame_done_o) begin ok = 1'b1; t0 = cyc; break; end
    end
    if (!ok) timeout("frame1");
    chk("vsync_pclk_periods", 32'(vs_n), 32'd19);
    chk("href_pclk_periods",  32'(hr_n), 32'd32);
    for (int i = 0; i < 16; i++) chk("bar_byte", 32'(bytes[i]), 32'(BAR_BYTES[i]));
    chk("no_gap_1", 32'(vsync_o), 32'h1);
    @(negedge clk); chk("done_single", 32'(frame_done_o), 32'h0);

    // Frames 2 and 3: continuous enable
    wait_done("frame2", t1);
    chk("done_spacing_1", 32'(t1 - t0), 32'd190);
    chk("no_gap_2", 32'(vsync_o), 32'h1);
    sel = 2'd1;
    wait_done("frame3", t2);
    chk("done_spacing_2", 32'(t2 - t1), 32'd190);
    chk("fcnt_after_3", 32'(frame_cnt_o), 32'd3);

    // Frame 4: counter mode, enable dropped mid-active
    nb = 0; prev_href = 1'b0; ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (prev_href && !href_o) chk("cnt_blank_zero", 32'(cam_data_o), 32'h0);
      prev_href = href_o;
      if (pclk_o && href_o) begin
        if (nb < 32) bytes[nb] = cam_data_o;
        nb++;
        if (nb == 20) en = 1'b0;
      end
      if (frame_done_o) begin ok = 1'b1; break; end
    end
    if (!ok) timeout("frame4");
    chk("cnt_y0_last", 32'(bytes[15]), 32'h0F);
    for (int i = 0; i < 16; i++) chk("cnt_y1_byte", 32'(bytes[16 + i]), 32'(i + 1));
    chk("drop_fcnt", 32'(frame_cnt_o), 32'd4);
    vs_n = 0;
    repeat (60) begin
      @(negedge clk);
      if (vsync_o || href_o) vs_n++;
    end
    chk("idle_quiet", 32'(vs_n), 32'd0);

    // Frame 5: solid 1234, value changed mid-frame
    sel = 2'd2; solid = 16'h1234; en = 1'b1;
    nb = 0; seen_vs = 1'b0; ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (vsync_o) seen_vs = 1'b1;
      if (seen_vs && !vsync_o) solid = 16'hABCD;
      if (pclk_o && href_o) begin
        if (nb < 32) bytes[nb] = cam_data_o;
        nb++;
      end
      if (frame_done_o) begin ok = 1'b1; break; end
    end
    if (!ok) timeout("frame5");
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      if (bytes[i] !== ((i % 2 == 1) ? 8'h34 : 8'h12)) bad++;
    end
    chk("solid_nbytes", 32'(nb), 32'd32);
    chk("solid_pairs_bad", 32'(bad), 32'd0);

    // Frame 6 picks up the new solid value; reset it mid-active
    nb = 0; ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (pclk_o && href_o) begin
        if (nb == 0) chk("solid_next_hi", 32'(cam_data_o), 32'hAB);
        if (nb == 1) chk("solid_next_lo", 32'(cam_data_o), 32'hCD);
        nb++;
      end
      if (nb == 6) begin ok = 1'b1; break; end
    end
    if (!ok) timeout("frame6");
    chk("pre_rst_href", 32'(href_o), 32'h1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pclk",  32'(pclk_o),       32'h0);
    chk("arst_vsync", 32'(vsync_o),      32'h0);
    chk("arst_href",  32'(href_o),       32'h0);
    chk("arst_data",  32'(cam_data_o),   32'h0);
    chk("arst_done",  32'(frame_done_o), 32'h0);
    chk("arst_fcnt",  32'(frame_cnt_o),  32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1; en = 1'b1; sel = 2'd0;
    @(negedge clk); chk("fresh_lat_rise", 32'(vsync_o), 32'h0);
    @(negedge clk); chk("fresh_vsync", 32'(vsync_o), 32'h1);
    t0 = cyc;
    wait_done("fresh_frame", t1);
    chk("fresh_frame_len", 32'(t1 - t0), 32'd190);
    chk("fresh_fcnt", 32'(frame_cnt_o), 32'd1);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
